// File: rtl/instr_fetch.sv
// instr_fetch: PC owner, instruction memory request/ready fetch, hold-for-execute and redirect/halt control
module instr_fetch #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        im_rd_en,
    output logic [15:0] im_addr,
    input  logic        im_rdy,
    input  logic [15:0] im_data,
    output logic [15:0] instr,
    output logic        instr_vld,
    output logic [15:0] pc,
    output logic [15:0] pc_inc,
    input  logic        stall,
    input  logic        hlt,
    input  logic        br_taken,
    input  logic [15:0] br_tgt,
    input  logic        jmp,
    input  logic [15:0] jmp_tgt,
    output logic        halted,
    output logic        fetch_err,
    output logic [15:0] retire_cnt
);
    localparam int WW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    state_t        state_q, state_d;
    logic [15:0]   pc_q, pc_d, instr_q, instr_d, retire_q, retire_d;
    logic [WW-1:0] wait_q, wait_d, wait_inc;
    logic          err_q, err_d, timeout;

    assign wait_inc   = wait_q + 1'b1;
    assign timeout    = (MAX_WAIT != 0) && (wait_inc == WW'(MAX_WAIT));
    assign pc_inc     = pc_q + 16'd1;
    assign pc         = pc_q;
    assign im_addr    = pc_q;
    assign instr      = instr_q;
    assign retire_cnt = retire_q;
    assign fetch_err  = err_q;
    assign im_rd_en   = state_q == FETCH;
    assign instr_vld  = state_q == EXEC;
    assign halted     = state_q == HALT;

    // Next-state: fetch handshake with timeout, commit with hlt > jmp > branch > sequential priority
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        retire_d = retire_q;
        wait_d   = wait_q;
        err_d    = err_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (im_rdy) begin
                    instr_d = im_data;
                    wait_d  = '0;
                    state_d = EXEC;
                end else begin
                    wait_d  = wait_inc;
                    state_d = timeout ? HALT : FETCH;
                    err_d   = err_q | timeout;
                end
            end
            EXEC: begin
                if (!stall) begin
                    retire_d = retire_q + 16'd1;
                    state_d  = hlt ? HALT : FETCH;
                    pc_d     = hlt ? pc_q : jmp ? jmp_tgt : br_taken ? br_tgt : pc_inc;
                end
            end
            default: ;
        endcase
    end

    // State register with asynchronous reset, effective immediately even mid-fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= PC_RESET;
            instr_q  <= 16'h0000;
            retire_q <= 16'h0000;
            wait_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            retire_q <= retire_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus with a commit scoreboard for instr_fetch
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        im_rd_en, im_rdy = 1'b0, instr_vld, stall = 1'b0, hlt = 1'b0;
    logic        br_taken = 1'b0, jmp = 1'b0, halted, fetch_err;
    logic [15:0] im_addr, im_data, instr, pc, pc_inc, retire_cnt;
    logic [15:0] br_tgt = 16'h0000, jmp_tgt = 16'h0000;
    logic [15:0] mem [0:255];

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ins;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign im_data = mem[im_addr[7:0]];

    instr_fetch #(.PC_RESET(16'h0000), .MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n), .im_rd_en(im_rd_en), .im_addr(im_addr),
        .im_rdy(im_rdy), .im_data(im_data), .instr(instr), .instr_vld(instr_vld),
        .pc(pc), .pc_inc(pc_inc), .stall(stall), .hlt(hlt), .br_taken(br_taken),
        .br_tgt(br_tgt), .jmp(jmp), .jmp_tgt(jmp_tgt), .halted(halted),
        .fetch_err(fetch_err), .retire_cnt(retire_cnt)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_exec(input logic [15:0] a);
        int n = 0;
        while (!(instr_vld && pc == a) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL wait_exec actual_pc=%h expected_pc=%h", pc, a);
        end
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_pc"}, pc, 16'h0000);
        chk({tag, "_pc_inc"}, pc_inc, 16'h0001);
        chk({tag, "_instr"}, instr, 16'h0000);
        chk({tag, "_vld"}, {15'd0, instr_vld}, 16'd0);
        chk({tag, "_rd_en"}, {15'd0, im_rd_en}, 16'd0);
        chk({tag, "_halted"}, {15'd0, halted}, 16'd0);
        chk({tag, "_err"}, {15'd0, fetch_err}, 16'd0);
        chk({tag, "_retire"}, retire_cnt, 16'd0);
    endtask

    // Scoreboard monitor: every commit must match the next queued expectation
    always @(negedge clk) begin
        if (rst_n && instr_vld && !stall) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL commit_unexpected actual_pc=%h expected=none", pc);
            end else begin
                e = q.pop_front();
                chk("commit_pc", pc, e.pc);
                chk("commit_instr", instr, e.ins);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        mem[4] = 16'h5555; mem[5] = 16'h6666; mem[7] = 16'h7777;
        mem[8'h20] = 16'h2020; mem[8'h30] = 16'h3030; mem[8'h40] = 16'h4040;
        q.push_back('{16'h0000, 16'h1111}); q.push_back('{16'h0001, 16'h2222});
        q.push_back('{16'h0002, 16'h3333}); q.push_back('{16'h0003, 16'h4444});
        q.push_back('{16'h0004, 16'h5555}); q.push_back('{16'h0005, 16'h6666});
        q.push_back('{16'h0040, 16'h4040}); q.push_back('{16'h0005, 16'h6666});
        q.push_back('{16'h0020, 16'h2020}); q.push_back('{16'h0030, 16'h3030});
        q.push_back('{16'h0007, 16'h7777});
        im_rdy = 1'b1;
        tick(); tick();
        reset_chk("rst");
        rst_n = 1'b1;
        chk("idle_rd_en", {15'd0, im_rd_en}, 16'd0);
        // Sequential run: one request every two cycles at addresses 0,1,2
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("seq_vld", {15'd0, instr_vld}, {15'd0, i[0]});
            if (!i[0]) chk("seq_addr", im_addr, 16'(i / 2));
        end
        tick();
        chk("seq_retire", retire_cnt, 16'd3);
        // Jump beats branch
        wait_exec(16'h0005);
        jmp = 1'b1; jmp_tgt = 16'h0040; br_taken = 1'b1; br_tgt = 16'h0020;
        tick();
        chk("jmp_addr", im_addr, 16'h0040);
        chk("jmp_rd_en", {15'd0, im_rd_en}, 16'd1);
        jmp = 1'b0; br_taken = 1'b0;
        wait_exec(16'h0040);
        jmp = 1'b1; jmp_tgt = 16'h0005;
        tick();
        chk("back_addr", im_addr, 16'h0005);
        jmp = 1'b0;
        wait_exec(16'h0005);
        br_taken = 1'b1; br_tgt = 16'h0020; jmp_tgt = 16'h0040;
        tick();
        chk("br_addr", im_addr, 16'h0020);
        br_taken = 1'b0;
        // Stall freezes everything for four EXEC cycles
        wait_exec(16'h0020);
        chk("pre_stall_retire", retire_cnt, 16'd8);
        stall = 1'b1; br_taken = 1'b1; br_tgt = 16'h0030;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_instr", instr, 16'h2020);
            chk("stall_pc", pc, 16'h0020);
            chk("stall_retire", retire_cnt, 16'd8);
            chk("stall_rd_en", {15'd0, im_rd_en}, 16'd0);
        end
        stall = 1'b0;
        tick();
        chk("unstall_addr", im_addr, 16'h0030);
        chk("unstall_retire", retire_cnt, 16'd9);
        br_taken = 1'b0;
        // HLT wins over jmp and halts with pc on the HLT instruction
        wait_exec(16'h0030);
        jmp = 1'b1; jmp_tgt = 16'h0007;
        tick();
        jmp = 1'b0;
        wait_exec(16'h0007);
        hlt = 1'b1; jmp = 1'b1; jmp_tgt = 16'h0050;
        tick();
        chk("hlt_halted", {15'd0, halted}, 16'd1);
        chk("hlt_pc", pc, 16'h0007);
        chk("hlt_retire", retire_cnt, 16'd11);
        chk("hlt_err", {15'd0, fetch_err}, 16'd0);
        for (int i = 0; i < 20; i++) begin
            im_rdy = i[0]; hlt = i[1]; stall = i[2];
            tick();
            chk("halt_rd_en", {15'd0, im_rd_en}, 16'd0);
            chk("halt_vld", {15'd0, instr_vld}, 16'd0);
            chk("halt_pc", pc, 16'h0007);
            chk("halt_retire", retire_cnt, 16'd11);
        end
        hlt = 1'b0; jmp = 1'b0; stall = 1'b0;
        chk("queue_drained", 16'(q.size()), 16'd0);
        // Timeout after 15 FETCH cycles without im_rdy
        rst_n = 1'b0; im_rdy = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) tick();
        chk("to_15th_rd_en", {15'd0, im_rd_en}, 16'd1);
        chk("to_15th_halted", {15'd0, halted}, 16'd0);
        tick();
        chk("to_halted", {15'd0, halted}, 16'd1);
        chk("to_err", {15'd0, fetch_err}, 16'd1);
        chk("to_rd_en", {15'd0, im_rd_en}, 16'd0);
        // im_rdy on the 15th FETCH cycle succeeds
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) tick();
        im_rdy = 1'b1;
        q.push_back('{16'h0000, 16'h1111});
        tick();
        chk("late_vld", {15'd0, instr_vld}, 16'd1);
        chk("late_instr", instr, 16'h1111);
        chk("late_err", {15'd0, fetch_err}, 16'd0);
        chk("late_halted", {15'd0, halted}, 16'd0);
        im_rdy = 1'b0; jmp = 1'b1; jmp_tgt = 16'h0009;
        tick();
        jmp = 1'b0;
        chk("mid_addr", im_addr, 16'h0009);
        chk("mid_rd_en", {15'd0, im_rd_en}, 16'd1);
        chk("mid_retire", retire_cnt, 16'd1);
        tick();
        // Asynchronous reset in the middle of a fetch
        rst_n = 1'b0;
        #1;
        reset_chk("async");
        tick();
        reset_chk("held");
        rst_n = 1'b1;
        chk("rel_idle_rd_en", {15'd0, im_rd_en}, 16'd0);
        tick();
        chk("rel_rd_en", {15'd0, im_rd_en}, 16'd1);
        chk("rel_addr", im_addr, 16'h0000);
        chk("final_queue", 16'(q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
